// File: rtl/memc_collect_pkg.sv
// memc_collect shared types: FSM state encoding and counter width helper.
// One flop per active state so busy/ready come straight off registers.
package memc_collect_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'b00;
    localparam state_t ST_FILL  = 2'b01;
    localparam state_t ST_READY = 2'b10;

    function automatic int cnt_w(input int dim);
        return $clog2(2 * dim);
    endfunction

endpackage

// File: rtl/deskew_line.sv
// deskew_line: enable-gated shift register of DELAY stages.
// DELAY=0 degenerates to a plain wire.
module deskew_line #(
    parameter int BITS  = 24,
    parameter int DELAY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic signed [BITS-1:0] d,
    output logic signed [BITS-1:0] q
);

    if (DELAY == 0) begin : g_wire
        logic unused_ctl;
        assign unused_ctl = &{1'b0, clk, rst_n, en};
        assign q = d;
    end else begin : g_sr
        logic signed [BITS-1:0] sr [DELAY];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DELAY; i++) sr[i] <= '0;
            end else if (en) begin
                sr[0] <= d;
                for (int i = 1; i < DELAY; i++) sr[i] <= sr[i-1];
            end
        end

        assign q = sr[DELAY-1];
    end

endmodule

// File: rtl/memc_collect.sv
// memc_collect: output-side collector for the systolic array.
// Re-aligns skewed column drains into a DIM x DIM store; row reads.
module memc_collect
    import memc_collect_pkg::*;
#(
    parameter int BITS_C = 24,
    parameter int DIM    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     drain,
    input  logic signed [BITS_C-1:0] Cin [DIM],
    input  logic                     rd_en,
    input  logic [$clog2(DIM)-1:0]   Crow,
    output logic signed [BITS_C-1:0] Cout [DIM],
    output logic                     busy,
    output logic                     ready,
    output logic                     done
);

    localparam int CNT_W = cnt_w(DIM);
    localparam logic [CNT_W-1:0] FIRST = CNT_W'(DIM - 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(2 * DIM - 2);

    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic signed [BITS_C-1:0] aligned [DIM];
    logic signed [BITS_C-1:0] store [DIM][DIM];
    logic                     wr_en;
    logic [CNT_W-1:0]         wr_row;
    logic                     row_ok;

    for (genvar j = 0; j < DIM; j++) begin : g_col
        deskew_line #(
            .BITS  (BITS_C),
            .DELAY (DIM - 1 - j)
        ) u_line (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .d     (Cin[j]),
            .q     (aligned[j])
        );
    end

    assign wr_en  = (state == ST_FILL) && (cnt >= FIRST);
    assign wr_row = cnt - FIRST;
    assign row_ok = int'(Crow) < DIM;
    assign busy   = state[0];
    assign ready  = state[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else if (en) begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE, ST_READY: begin
                    if (drain) begin
                        state <= ST_FILL;
                        cnt   <= CNT_W'(1);
                    end
                end
                ST_FILL: begin
                    if (cnt == LAST) begin
                        state <= ST_READY;
                        cnt   <= '0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++)
                    store[i][j] <= '0;
        end else if (en && wr_en) begin
            for (int i = 0; i < DIM; i++)
                if (wr_row == CNT_W'(i))
                    for (int j = 0; j < DIM; j++)
                        store[i][j] <= aligned[j];
        end
    end

    // Non-blocking read of store gives the old row on a same-edge write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DIM; j++) Cout[j] <= '0;
        end else if (en && rd_en) begin
            for (int j = 0; j < DIM; j++)
                Cout[j] <= row_ok ? store[Crow][j] : '0;
        end
    end

endmodule

// File: tb/tb_memc_collect.sv
// tb_memc_collect: directed table reads, multi-cycle corner sequences,
// and randomized traffic against a matrix-level reference model.
module tb_memc_collect;

    localparam int DIM    = 8;
    localparam int BITS_C = 24;
    localparam int NT     = 7;

    typedef logic signed [BITS_C-1:0] elem_t;

    typedef struct {
        int   phase;
        int   row;
        int   scale;
        logic exp_ready;
    } vec_t;

    logic                   clk   = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   en    = 1'b0;
    logic                   drain = 1'b0;
    logic                   rd_en = 1'b0;
    logic [$clog2(DIM)-1:0] Crow  = '0;
    elem_t                  Cin  [DIM];
    elem_t                  Cout [DIM];
    logic                   busy;
    logic                   ready;
    logic                   done;

    memc_collect #(
        .BITS_C (BITS_C),
        .DIM    (DIM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .drain (drain),
        .Cin   (Cin),
        .rd_en (rd_en),
        .Crow  (Crow),
        .Cout  (Cout),
        .busy  (busy),
        .ready (ready),
        .done  (done)
    );

    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    vec_t  tbl [NT];

    // Reference model: whole matrices plus the drain schedule.
    elem_t ms  [DIM][DIM];
    elem_t cur [DIM][DIM];
    elem_t nxt [DIM][DIM];
    elem_t exp_cout [DIM];
    int    m_mode;
    int    t_fill;
    logic  m_done;

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_cout(input string nm);
        int bad;
        bad = -1;
        checks++;
        for (int j = 0; j < DIM; j++)
            if (Cout[j] !== exp_cout[j]) bad = j;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s[%0d] @%0t: got %0d want %0d",
                     nm, bad, $time, Cout[bad], exp_cout[bad]);
        end
    endtask

    task automatic chk_row(input string nm, input int row, input int scale);
        int bad;
        elem_t want;
        bad = -1;
        checks++;
        for (int j = 0; j < DIM; j++) begin
            want = elem_t'(scale * (16 * row + j));
            if (Cout[j] !== want) bad = j;
        end
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d want %0d", nm, bad,
                     Cout[bad], elem_t'(scale * (16 * row + bad)));
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < DIM; r++) begin
            exp_cout[r] = '0;
            for (int c = 0; c < DIM; c++) ms[r][c] = '0;
        end
        m_mode = 0;
        t_fill = 0;
        m_done = 1'b0;
    endtask

    task automatic set_nxt(input int kind);
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                nxt[r][c] = (kind == 0) ? elem_t'(16 * r + c) :
                            (kind == 1) ? elem_t'(-(16 * r + c)) :
                                          elem_t'($urandom);
    endtask

    // One clock: array drives its skewed diagonal, model tracks the edge.
    task automatic cyc(input bit e, input bit dr, input bit rd, input int row);
        bit start;
        int t;
        int r;
        start = e && dr && (m_mode != 1);
        if (start) cur = nxt;
        t = start ? 0 : t_fill;
        for (int j = 0; j < DIM; j++) begin
            r = t - j;
            if (e && (start || m_mode == 1) && r >= 0 && r < DIM)
                Cin[j] = cur[r][j];
            else
                Cin[j] = elem_t'($urandom);
        end
        en    = e;
        drain = dr;
        rd_en = rd;
        Crow  = ($clog2(DIM))'(row);
        @(posedge clk);
        if (e) begin
            if (rd) exp_cout = ms[row];
            m_done = 1'b0;
            if (m_mode == 1) begin
                if (t_fill >= DIM - 1)
                    ms[t_fill - (DIM - 1)] = cur[t_fill - (DIM - 1)];
                if (t_fill == 2 * DIM - 2) begin
                    m_mode = 2;
                    m_done = 1'b1;
                end else begin
                    t_fill++;
                end
            end else if (dr) begin
                m_mode = 1;
                t_fill = 1;
            end
        end
        #1;
        chk("busy", busy, m_mode == 1);
        chk("ready", ready, m_mode == 2);
        chk("done", done, m_done);
        chk_cout("cout");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", ready, 1'b0);
        chk("rst_done", done, 1'b0);
        chk_cout("rst_cout");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_to_done(input int first, input int stall_at,
                               input int stall_len, input int redrain_at,
                               output int n);
        int el;
        el = first - 1;
        n  = -1;
        for (int i = first; i <= 40 && n < 0; i++) begin
            if (i == stall_at) begin
                repeat (stall_len) begin
                    cyc(1'b0, 1'b0, 1'b0, 0);
                    el++;
                end
            end
            cyc(1'b1, i == redrain_at, 1'b0, 0);
            el++;
            if (done) n = el;
        end
    endtask

    task automatic apply_tbl(input int ph);
        for (int k = 0; k < NT; k++) begin
            if (tbl[k].phase == ph) begin
                cyc(1'b1, 1'b0, 1'b1, tbl[k].row);
                chk_row($sformatf("tbl%0d_row", k), tbl[k].row, tbl[k].scale);
                chk($sformatf("tbl%0d_ready", k), ready, tbl[k].exp_ready);
            end
        end
    endtask

    task automatic read_all();
        for (int r = 0; r < DIM; r++) cyc(1'b1, 1'b0, 1'b1, r);
    endtask

    initial begin
        int n;
        bit e;
        bit dr;

        tbl[0] = '{phase: 0, row: 3, scale:  1, exp_ready: 1'b1};
        tbl[1] = '{phase: 0, row: 0, scale:  1, exp_ready: 1'b1};
        tbl[2] = '{phase: 0, row: 7, scale:  1, exp_ready: 1'b1};
        tbl[3] = '{phase: 0, row: 5, scale:  1, exp_ready: 1'b1};
        tbl[4] = '{phase: 1, row: 0, scale: -1, exp_ready: 1'b1};
        tbl[5] = '{phase: 1, row: 3, scale: -1, exp_ready: 1'b1};
        tbl[6] = '{phase: 1, row: 7, scale: -1, exp_ready: 1'b1};

        for (int j = 0; j < DIM; j++) Cin[j] = '0;
        model_reset();
        set_nxt(0);
        cur = nxt;

        #1;
        do_reset();
        read_all();

        // Plain drain of 16*r+j.
        set_nxt(0);
        cyc(1'b1, 1'b1, 1'b0, 0);
        run_to_done(1, 0, 0, 0, n);
        chk("done_edge_plain", n, 14);
        apply_tbl(0);

        // Same drain with a 3-cycle global stall mid-FILL.
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 0);
        run_to_done(1, 5, 3, 0, n);
        chk("done_edge_stall", n, 17);
        cyc(1'b0, 1'b0, 1'b0, 0);
        apply_tbl(0);

        // Stray drain pulse during FILL.
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 0);
        run_to_done(1, 0, 0, 5, n);
        chk("done_edge_redrain", n, 14);
        apply_tbl(0);

        // Refill from READY; read row 0 on and after its write edge.
        set_nxt(1);
        cyc(1'b1, 1'b1, 1'b0, 0);
        chk("refill_ready_drop", ready, 1'b0);
        for (int i = 1; i <= 6; i++) cyc(1'b1, 1'b0, 1'b0, 0);
        cyc(1'b1, 1'b0, 1'b1, 0);
        chk_row("rbw_old_row0", 0, 1);
        cyc(1'b1, 1'b0, 1'b1, 0);
        chk_row("rbw_new_row0", 0, -1);
        run_to_done(9, 0, 0, 0, n);
        chk("done_edge_refill", n, 14);
        apply_tbl(1);

        // Async reset mid-FILL, then a clean drain.
        set_nxt(0);
        cyc(1'b1, 1'b1, 1'b0, 0);
        for (int i = 1; i <= 9; i++) cyc(1'b1, 1'b0, 1'b0, 0);
        do_reset();
        read_all();
        set_nxt(2);
        cyc(1'b1, 1'b1, 1'b0, 0);
        run_to_done(1, 0, 0, 0, n);
        chk("done_edge_after_rst", n, 14);
        read_all();

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            if (m_mode != 1) set_nxt(2);
            e  = ($urandom_range(0, 9) < 8);
            dr = ($urandom_range(0, 11) == 0);
            cyc(e, dr, $urandom_range(0, 1) == 1, $urandom_range(0, DIM - 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
